sos_scheduler: RTL and testbench

Sequencer that time-multiplexes one shared second-order-section (SOS) engine across `SECTIONS` cascaded biquad stages. Each accepted audio sample passes through stages 0..`SECTIONS-1` in order, and the block returns one rounded, saturated output word. It sits between the sample source (ADC strobe) and the FFT input buffer. It replaces a chain of dedicated section instances, so the multipliers are spent only once.

---
 rtl/sos_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sos_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sos_scheduler.sv
// Sequencer that time-multiplexes one shared biquad (SOS) engine across SECTIONS
// cascaded stages, returning one rounded and saturated word per accepted sample.
module sos_scheduler #(
  parameter int WORD_SIZE  = 16,
  parameter int ACCUM_SIZE = 32,
  parameter int SECTIONS   = 4,
  parameter int SEC_BITS   = 4,
  parameter int OVR_BITS   = 8
) (
  input  logic                  inClock,
  input  logic                  reset,
  input  logic [WORD_SIZE-1:0]  inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [WORD_SIZE-1:0]  outData,
  output logic                  outValid,
  output logic                  engStart,
  output logic                  engClear,
  output logic [SEC_BITS-1:0]   engSection,
  output logic [ACCUM_SIZE-1:0] engIn,
  input  logic [ACCUM_SIZE-1:0] engOut,
  input  logic                  engDone,
  output logic [OVR_BITS-1:0]   overrunCount
);

  localparam int FRAC_BITS = ACCUM_SIZE - WORD_SIZE;
  localparam logic [SEC_BITS-1:0] LAST_SEC = SEC_BITS'(SECTIONS - 1);
  localparam logic [SEC_BITS-1:0] SEC_ONE  = {{(SEC_BITS-1){1'b0}}, 1'b1};
  localparam logic [OVR_BITS-1:0] OVR_ONE  = {{(OVR_BITS-1){1'b0}}, 1'b1};
  localparam logic [OVR_BITS-1:0] OVR_MAX  = {OVR_BITS{1'b1}};
  localparam logic signed [ACCUM_SIZE:0] RND_HALF =
    {{ACCUM_SIZE{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACCUM_SIZE:0] SAT_MAX =
    {{(FRAC_BITS+2){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACCUM_SIZE:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  state_t                  state_r;
  logic [SEC_BITS-1:0]     k_r;
  logic [SEC_BITS-1:0]     sec_r;
  logic [ACCUM_SIZE-1:0]   work_r;
  logic [WORD_SIZE-1:0]    out_data_r;
  logic                    out_valid_r;
  logic                    ready_r;
  logic                    start_r;
  logic                    clear_r;
  logic [OVR_BITS-1:0]     overrun_r;

  // The sum is one bit wider than the accumulator so the rounding offset cannot wrap.
  function automatic logic [WORD_SIZE-1:0] sat_round(input logic [ACCUM_SIZE-1:0] a);
    logic signed [ACCUM_SIZE:0] sum;
    logic signed [ACCUM_SIZE:0] shr;
    sum = $signed({a[ACCUM_SIZE-1], a}) + RND_HALF;
    shr = sum >>> FRAC_BITS;
    if (shr > SAT_MAX) begin
      sat_round = {1'b0, {(WORD_SIZE-1){1'b1}}};
    end else if (shr < SAT_MIN) begin
      sat_round = {1'b1, {(WORD_SIZE-1){1'b0}}};
    end else begin
      sat_round = shr[WORD_SIZE-1:0];
    end
  endfunction

  // Sequencer: clears every section, then walks each sample through the cascade.
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_INIT;
      k_r         <= '0;
      sec_r       <= '0;
      work_r      <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      ready_r     <= 1'b0;
      start_r     <= 1'b0;
      clear_r     <= 1'b0;
    end else begin
      start_r     <= 1'b0;
      clear_r     <= 1'b0;
      out_valid_r <= 1'b0;
      case (state_r)
        ST_INIT: begin
          clear_r <= 1'b1;
          sec_r   <= k_r;
          if (k_r == LAST_SEC) begin
            k_r     <= '0;
            state_r <= ST_IDLE;
          end else begin
            k_r <= k_r + SEC_ONE;
          end
        end
        ST_IDLE: begin
          // The first IDLE cycle after INIT still shows inReady low; acceptance follows the registered flag.
          if (inValid && ready_r) begin
            work_r  <= {inData, {FRAC_BITS{1'b0}}};
            k_r     <= '0;
            sec_r   <= '0;
            start_r <= 1'b1;
            ready_r <= 1'b0;
            state_r <= ST_ISSUE;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (engDone) begin
            work_r <= engOut;
            if (k_r == LAST_SEC) begin
              out_data_r  <= sat_round(engOut);
              out_valid_r <= 1'b1;
              state_r     <= ST_EMIT;
            end else begin
              k_r     <= k_r + SEC_ONE;
              sec_r   <= k_r + SEC_ONE;
              start_r <= 1'b1;
              state_r <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_EMIT: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          k_r     <= '0;
          ready_r <= 1'b0;
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  // Saturating count of samples offered while the block was busy.
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      overrun_r <= '0;
    end else if (inValid && !ready_r && (overrun_r != OVR_MAX)) begin
      overrun_r <= overrun_r + OVR_ONE;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign inReady      = ready_r;
  assign outData      = out_data_r;
  assign outValid     = out_valid_r;
  assign engStart     = start_r;
  assign engClear     = clear_r;
  assign engSection   = sec_r;
  assign engIn        = work_r;
  assign overrunCount = overrun_r;

endmodule

// File: tb/tb_sos_scheduler.sv
// Scoreboard bench for sos_scheduler with a behavioural SOS engine of selectable
// latency and transfer function.
module tb_sos_scheduler;

  localparam int W  = 16;
  localparam int A  = 32;
  localparam int S  = 4;
  localparam int SB = 4;
  localparam int OB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  inData;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  outData;
  logic          outValid;
  logic          engStart;
  logic          engClear;
  logic [SB-1:0] engSection;
  logic [A-1:0]  engIn;
  logic [A-1:0]  engOut;
  logic          engDone;
  logic [OB-1:0] overrunCount;

  sos_scheduler #(.WORD_SIZE(W), .ACCUM_SIZE(A), .SECTIONS(S), .SEC_BITS(SB), .OVR_BITS(OB)) dut (
    .inClock(clk), .reset(rst), .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .engStart(engStart), .engClear(engClear),
    .engSection(engSection), .engIn(engIn), .engOut(engOut), .engDone(engDone),
    .overrunCount(overrunCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  typedef struct { logic [W-1:0] data; int cyc; } out_t;
  typedef struct { logic [SB-1:0] sec; int cyc; } st_t;
  out_t out_q[$];
  st_t  st_q[$];

  int           lat    = 1;
  int           mode   = 0;
  logic [A-1:0] constv = '0;
  bit           inject = 1'b0;
  int           ecnt   = 0;
  logic [A-1:0] eres   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine: mode 0 identity, mode 1 adds half an LSB in section 0, else a constant.
  initial begin
    engDone = 1'b0;
    engOut  = '0;
    forever begin
      @(negedge clk);
      engDone = 1'b0;
      if (rst) begin
        ecnt = 0;
      end else begin
        if (ecnt > 0) begin
          ecnt--;
          if (ecnt == 0) begin
            engDone = 1'b1;
            engOut  = eres;
          end
        end
        if (inject) begin
          engDone = 1'b1;
          engOut  = 32'hDEAD_BEEF;
          inject  = 1'b0;
        end
        if (engStart) begin
          ecnt = lat;
          case (mode)
            0:       eres = engIn;
            1:       eres = (engSection == 4'd0) ? engIn + 32'h0000_8000 : engIn;
            default: eres = constv;
          endcase
        end
      end
    end
  end

  // Monitor: every outValid and engStart must match the head of its queue.
  initial begin
    out_t eo;
    st_t  es;
    forever begin
      @(negedge clk);
      if (!rst && outValid) begin
        if (out_q.size() == 0) begin
          check("unexpected_outValid", 64'd1, 64'd0);
        end else begin
          eo = out_q.pop_front();
          check("outData", 64'(outData), 64'(eo.data));
          check("outValid_cycle", 64'(cyc), 64'(eo.cyc));
        end
      end
      if (!rst && engStart) begin
        if (st_q.size() == 0) begin
          check("unexpected_engStart", 64'd1, 64'd0);
        end else begin
          es = st_q.pop_front();
          check("engSection", 64'(engSection), 64'(es.sec));
          check("engStart_cycle", 64'(cyc), 64'(es.cyc));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] exp);
    int n;
    int t;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("inReady_wait", 64'(inReady), 64'd1);
    inData  = d;
    inValid = 1'b1;
    t = cyc;
    for (int k = 0; k < S; k++) st_q.push_back('{SB'(k), t + 1 + k * (lat + 1)});
    out_q.push_back('{exp, t + S * (lat + 1) + 1});
    @(negedge clk);
    inValid = 1'b0;
    check("busy_after_accept", 64'(inReady), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(out_q.size()), 64'd0);
  endtask

  task automatic init_check();
    for (int i = 0; i < S; i++) begin
      @(negedge clk);
      check("init_clear", {engClear, engSection, inReady}, {1'b1, 4'(i), 1'b0});
    end
    @(negedge clk);
    check("init_ready", {engClear, inReady}, 2'b01);
  endtask

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {inReady, outValid, engStart, engClear, engSection, engIn, outData, overrunCount},
          64'd0);
    rst = 1'b0;
    init_check();

    mode = 0; lat = 1;
    send(16'h1234, 16'h1234);
    drain();

    mode = 1;
    send(16'h0005, 16'h0006);
    drain();
    mode = 2; constv = 32'h7FFF_FFFF;
    send(16'h0100, 16'h7FFF);
    drain();
    constv = 32'h8000_0000;
    send(16'h0100, 16'h8000);
    drain();

    mode = 0; lat = 4;
    send(16'h0F0F, 16'h0F0F);
    inData = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inValid = 1'b1;
      @(negedge clk); inValid = 1'b0;
    end
    check("overrun_3", 64'(overrunCount), 64'd3);
    drain();

    lat = 80;
    send(16'h8001, 16'h8001);
    inData  = 16'h1111;
    inValid = 1'b1;
    repeat (300) @(negedge clk);
    inValid = 1'b0;
    check("overrun_sat", 64'(overrunCount), 64'd255);
    drain();

    lat = 3;
    send(16'hABCD, 16'hABCD);
    drain();
    inject = 1'b1;
    repeat (5) @(negedge clk);
    check("spurious_idle", {outValid, engStart, inReady}, 3'b001);
    send(16'h0042, 16'h0042);
    drain();

    lat = 2;
    send(16'h2222, 16'h2222);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    out_q.delete();
    st_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_check();
    check("overrun_after_reset", 64'(overrunCount), 64'd0);
    send(16'h3333, 16'h3333);
    drain();
    repeat (5) @(negedge clk);
    check("queues_empty", 64'(st_q.size() + out_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
